// File: rtl/c0_5_ctrl_pkg.sv
// Shared types, limits and the preset clamp for the mod-6 counter control stage.
package c0_5_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } ctrl_state_t;

  localparam logic [2:0] C0_5_MAX = 3'd5;

  // The counter has no 6 or 7 state, so those presets fold back to 0.
  function automatic logic [2:0] clamp_preset(input logic [2:0] v);
    return (v > C0_5_MAX) ? 3'd0 : v;
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for one raw button.
module debounce_edge
  import c0_5_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/c0_5_ctrl.sv
// Run/stop/preset controller feeding the mod-6 up/down counter: enable ticks, direction and async preset bus.
module c0_5_ctrl
  import c0_5_ctrl_pkg::*;
#(
  parameter int PRESCALE    = 4,
  parameter int DEBOUNCE    = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       btn_load,
  input  logic [2:0] preset,
  output logic       enable,
  output logic       reverse,
  output logic [0:5] load,
  output logic       busy
);

  localparam int PW = $clog2(PRESCALE);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  logic run_press;
  logic dir_press;
  logic load_press;

  debounce_edge #(.DEBOUNCE(DEBOUNCE)) u_db_run  (.clk(clk), .rst_n(rst_n), .raw(btn_run),  .press(run_press));
  debounce_edge #(.DEBOUNCE(DEBOUNCE)) u_db_dir  (.clk(clk), .rst_n(rst_n), .raw(btn_dir),  .press(dir_press));
  debounce_edge #(.DEBOUNCE(DEBOUNCE)) u_db_load (.clk(clk), .rst_n(rst_n), .raw(btn_load), .press(load_press));

  ctrl_state_t   state;
  ctrl_state_t   state_nxt;
  ctrl_state_t   ret_state;
  logic          capture;
  logic [2:0]    preset_q;
  logic [LW-1:0] load_cnt;
  logic [PW-1:0] pre_cnt;

  // Load press beats a simultaneous run press; presses during LOAD are dropped.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      STOP: begin
        if (load_press) begin
          state_nxt = LOAD;
          capture   = 1'b1;
        end else if (run_press) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (load_press) begin
          state_nxt = LOAD;
          capture   = 1'b1;
        end else if (run_press) begin
          state_nxt = STOP;
        end
      end
      LOAD: begin
        if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
          state_nxt = ret_state;
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOP;
      ret_state <= STOP;
      preset_q  <= 3'd0;
      load_cnt  <= '0;
      pre_cnt   <= '0;
      reverse   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ret_state <= state;
        preset_q  <= clamp_preset(preset);
      end
      load_cnt <= (state == LOAD) ? load_cnt + 1'b1 : '0;
      // Held at zero outside RUN so every entry to RUN starts a fresh period.
      if (state == RUN && state_nxt == RUN) begin
        pre_cnt <= (pre_cnt == PW'(PRESCALE - 1)) ? '0 : pre_cnt + 1'b1;
      end else begin
        pre_cnt <= '0;
      end
      if (dir_press) begin
        reverse <= ~reverse;
      end
    end
  end

  assign enable = (state == RUN) && (pre_cnt == PW'(PRESCALE - 1));
  assign busy   = (state == LOAD);

  always_comb begin
    load = '0;
    if (state == LOAD) begin
      for (int i = 0; i < 3; i++) begin
        load[2*i]   = preset_q[i];
        load[2*i+1] = ~preset_q[i];
      end
    end
  end

endmodule

// File: tb/tb_c0_5_ctrl.sv
// Bench for c0_5_ctrl: directed timing checks plus randomized buttons against a window-based model.
module tb_c0_5_ctrl;

  localparam int P  = 4;
  localparam int D  = 4;
  localparam int LC = 2;

  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOAD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_dir = 1'b0;
  logic       btn_load = 1'b0;
  logic [2:0] preset = 3'd0;
  logic       enable;
  logic       reverse;
  logic [0:5] load;
  logic       busy;

  always #5 clk = ~clk;

  c0_5_ctrl #(.PRESCALE(P), .DEBOUNCE(D), .LOAD_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_dir(btn_dir), .btn_load(btn_load),
    .preset(preset), .enable(enable), .reverse(reverse), .load(load), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw history per button; a level is accepted once the last D synchronized samples agree.
  bit [D:0]   hist [3];
  bit         m_lvl [3];
  bit         m_press [3];
  int         m_mode = M_STOP;
  int         m_ret  = M_STOP;
  int         m_age  = 0;
  int         m_left = 0;
  bit         m_rev  = 1'b0;
  logic [2:0] m_v    = 3'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        hist[b] = '0; m_lvl[b] = 1'b0; m_press[b] = 1'b0;
      end
      m_mode = M_STOP; m_ret = M_STOP; m_age = 0; m_left = 0; m_rev = 1'b0; m_v = 3'd0;
    end else begin
      bit raw [3];
      bit nl;
      raw[0] = btn_run; raw[1] = btn_dir; raw[2] = btn_load;
      if (m_press[1]) m_rev = ~m_rev;
      if (m_mode == M_LOAD) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = m_ret;
          m_age  = 1;
        end
      end else if (m_press[2]) begin
        m_ret  = m_mode;
        m_v    = (preset >= 3'd6) ? 3'd0 : preset;
        m_mode = M_LOAD;
        m_left = LC;
      end else if (m_press[0]) begin
        m_mode = (m_mode == M_STOP) ? M_RUN : M_STOP;
        m_age  = 1;
      end else if (m_mode == M_RUN) begin
        m_age++;
      end
      for (int b = 0; b < 3; b++) begin
        if (hist[b][D:1] == {D{1'b1}})  nl = 1'b1;
        else if (hist[b][D:1] == '0)    nl = 1'b0;
        else                            nl = m_lvl[b];
        m_press[b] = nl & ~m_lvl[b];
        m_lvl[b]   = nl;
        hist[b]    = {hist[b][D-1:0], raw[b]};
      end
    end
  end

  function automatic logic [5:0] exp_load();
    logic [5:0] e;
    e = '0;
    if (m_mode == M_LOAD) begin
      for (int i = 0; i < 3; i++) begin
        e[5-2*i] = m_v[i];
        e[4-2*i] = ~m_v[i];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    check("m_enable",  enable,  (m_mode == M_RUN) && (m_age % P == 0));
    check("m_busy",    busy,    m_mode == M_LOAD);
    check("m_reverse", reverse, m_rev);
    check("m_load",    load,    exp_load());
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset with random buttons
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_run = 1'($urandom); btn_dir = 1'($urandom); btn_load = 1'($urandom);
      preset = 3'($urandom);
      step();
    end
    check("rst_en", enable, 0); check("rst_busy", busy, 0);
    check("rst_load", load, 0); check("rst_rev", reverse, 0);
    btn_run = 0; btn_dir = 0; btn_load = 0;
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("post_rst_en", enable, 0); check("post_rst_busy", busy, 0);

    // Run press, ticks every P cycles, second press stops with no exit-cycle tick
    btn_run = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("run_tick", enable, (k == 10 || k == 14 || k == 18 || k == 22));
      if (k == 6)  btn_run = 0;
      if (k == 19) btn_run = 1;
      if (k == 25) btn_run = 0;
    end
    repeat (10) step();
    check("stopped_en", enable, 0);

    // Direction: 3-cycle glitch ignored, 10-cycle press toggles once after 7 cycles
    btn_dir = 1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 3) btn_dir = 0;
      check("dir_glitch", reverse, 0);
    end
    btn_dir = 1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 10) btn_dir = 0;
      check("dir_toggle", reverse, k >= 7);
    end
    repeat (6) step();

    // Preset 3 while running
    btn_run = 1;
    repeat (6) step();
    btn_run = 0;
    repeat (8) step();
    btn_load = 1; preset = 3'd3;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 6) btn_load = 0;
      if (k == 7 || k == 8) begin
        check("pre3_load", load, 6'b101001); check("pre3_busy", busy, 1);
        check("pre3_en", enable, 0);
      end else if (k >= 9) begin
        check("pre3_idle_load", load, 0); check("pre3_idle_busy", busy, 0);
        check("pre3_ret_en", enable, k == 12);
      end
    end

    // Stop, then preset 7 from STOP with a run press landing inside LOAD
    btn_run = 1;
    repeat (6) step();
    btn_run = 0;
    repeat (14) step();
    preset = 3'd7; btn_load = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) btn_run = 1;
      if (k == 6) btn_load = 0;
      if (k == 7) btn_run = 0;
      if (k == 7 || k == 8) begin
        check("clamp_load", load, 6'b010101); check("clamp_busy", busy, 1);
      end else if (k >= 9) begin
        check("clamp_ret_busy", busy, 0); check("clamp_ret_en", enable, 0);
      end
    end
    repeat (8) step();

    // Reset in the first LOAD cycle clears the bus without a clock edge
    preset = 3'd5; btn_load = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) btn_load = 0;
    end
    check("mid_busy", busy, 1);
    check("mid_load", load, 6'b100110);
    #1 rst_n = 1'b0;
    #1;
    check("arst_load", load, 0); check("arst_busy", busy, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("arst_stop_en", enable, 0); check("arst_stop_busy", busy, 0);

    // Randomized buttons against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 7) == 0) btn_run  = ~btn_run;
      if ($urandom_range(0, 7) == 0) btn_dir  = ~btn_dir;
      if ($urandom_range(0, 7) == 0) btn_load = ~btn_load;
      preset = 3'($urandom);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
